// File: rtl/nrs_subframe_scheduler.sv
// nrs_subframe_scheduler: tracks frame/subframe counters from the subframe
// strobe, selects NRS-bearing subframes and sequences the cinit requests and
// estimator acknowledgements for each of them.
module nrs_subframe_scheduler #(
    parameter int unsigned NUM_RUNS  = 4,
    parameter logic [9:0]  SKIP_MASK = 10'b0000100001,
    parameter bit          NSSS_SKIP = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sf_tick,
    input  logic       nf_load,
    input  logic [9:0] nf_in,
    input  logic       cinit_run,
    input  logic       est_ack,
    output logic       new_frame,
    output logic       new_subframe,
    output logic       first_run,
    output logic       last_run,
    output logic [4:0] cinit_ns,
    output logic [2:0] cinit_l,
    output logic [3:0] sf_num,
    output logic [9:0] nf_num,
    output logic       sf_done,
    output logic       sf_skipped,
    output logic       overrun
);

    localparam int unsigned     CW      = $clog2(NUM_RUNS + 1);
    localparam logic [CW-1:0]   RUNS    = CW'(NUM_RUNS);
    localparam logic [CW-1:0]   RUNS_M1 = CW'(NUM_RUNS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN,
        WAIT_ACK
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    sf_num_q, sf_num_d;
    logic [9:0]    nf_num_q, nf_num_d;
    logic          load_pend_q, load_pend_d;
    logic [CW-1:0] req_cnt_q, req_cnt_d;
    logic [CW-1:0] ack_cnt_q, ack_cnt_d;
    logic          sf_skipped_q, sf_skipped_d;
    logic          sf_done_q, sf_done_d;
    logic          overrun_q, overrun_d;

    logic          tick_acc;
    logic          sf_wrap;
    logic [3:0]    sf_inc;
    logic [9:0]    nf_inc;
    logic          skip_next;
    logic          complete;
    logic          accept;
    logic          seeding;
    logic [1:0]    run_sel;

    assign tick_acc = sf_tick & ~nf_load;
    assign sf_wrap  = (sf_num_q == 4'd9);
    assign sf_inc   = sf_wrap ? 4'd0 : sf_num_q + 4'd1;
    // A load parks the counters at sf9 of the loaded frame; the wrap that
    // follows must land on sf0 of that same frame, so the increment is held off.
    assign nf_inc   = nf_num_q + {9'd0, sf_wrap & ~load_pend_q};

    assign skip_next = SKIP_MASK[sf_inc]
                     | (NSSS_SKIP & (sf_inc == 4'd9) & ~nf_inc[0]);

    assign complete = (state_q == WAIT_ACK)
                    & ((ack_cnt_q == RUNS) | ((ack_cnt_q == RUNS_M1) & est_ack));

    // Frame/subframe counter next-state; a load wins over a coincident tick.
    always_comb begin
        sf_num_d    = sf_num_q;
        nf_num_d    = nf_num_q;
        load_pend_d = load_pend_q;
        if (nf_load) begin
            sf_num_d    = 4'd9;
            nf_num_d    = nf_in;
            load_pend_d = 1'b1;
        end else if (sf_tick) begin
            sf_num_d    = sf_inc;
            nf_num_d    = nf_inc;
            load_pend_d = 1'b0;
        end
    end

    // Subframe sequencing FSM: next state, run/ack counters and event pulses.
    always_comb begin
        state_d      = state_q;
        req_cnt_d    = req_cnt_q;
        ack_cnt_d    = ack_cnt_q;
        sf_skipped_d = 1'b0;
        sf_done_d    = 1'b0;
        overrun_d    = overrun_q;
        accept       = 1'b0;
        case (state_q)
            IDLE: begin
                accept = tick_acc;
            end
            START: begin
                req_cnt_d = '0;
                ack_cnt_d = '0;
                state_d   = RUN;
                overrun_d = overrun_q | tick_acc;
            end
            RUN: begin
                if (cinit_run) begin
                    req_cnt_d = req_cnt_q + CW'(1);
                    if (req_cnt_q == RUNS_M1) begin
                        state_d = WAIT_ACK;
                    end
                end
                if (est_ack && (ack_cnt_q != RUNS)) begin
                    ack_cnt_d = ack_cnt_q + CW'(1);
                end
                overrun_d = overrun_q | tick_acc;
            end
            WAIT_ACK: begin
                if (est_ack && (ack_cnt_q != RUNS)) begin
                    ack_cnt_d = ack_cnt_q + CW'(1);
                end
                if (complete) begin
                    sf_done_d = 1'b1;
                    state_d   = IDLE;
                    accept    = tick_acc;
                end else begin
                    overrun_d = overrun_q | tick_acc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Counters are cleared on entry to START so the run-0 indices are
        // already valid during the START cycle.
        if (accept) begin
            req_cnt_d = '0;
            ack_cnt_d = '0;
            if (skip_next) begin
                sf_skipped_d = 1'b1;
                state_d      = IDLE;
            end else begin
                state_d = START;
            end
        end
    end

    // State and counter registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            sf_num_q     <= 4'd9;
            nf_num_q     <= 10'd1023;
            load_pend_q  <= 1'b0;
            req_cnt_q    <= '0;
            ack_cnt_q    <= '0;
            sf_skipped_q <= 1'b0;
            sf_done_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sf_num_q     <= sf_num_d;
            nf_num_q     <= nf_num_d;
            load_pend_q  <= load_pend_d;
            req_cnt_q    <= req_cnt_d;
            ack_cnt_q    <= ack_cnt_d;
            sf_skipped_q <= sf_skipped_d;
            sf_done_q    <= sf_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign seeding = (state_q == RUN) | (state_q == WAIT_ACK);
    assign run_sel = 2'((req_cnt_q >= RUNS) ? RUNS_M1 : req_cnt_q);

    assign new_frame    = (state_q == START) & (sf_num_q == 4'd0);
    assign new_subframe = (state_q == START) & (sf_num_q != 4'd0);
    assign first_run    = seeding & (req_cnt_q == CW'(1));
    assign last_run     = seeding & (req_cnt_q == RUNS);
    assign cinit_ns     = {sf_num_q, 1'b0} + {4'd0, run_sel[1]};
    assign cinit_l      = 3'd5 + {2'd0, run_sel[0]};
    assign sf_num       = sf_num_q;
    assign nf_num       = nf_num_q;
    assign sf_done      = sf_done_q;
    assign sf_skipped   = sf_skipped_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_nrs_subframe_scheduler.sv
// Testbench for nrs_subframe_scheduler: randomized handshakes checked against
// an absolute-subframe-index reference model.
module tb_nrs_subframe_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       sf_tick;
    logic       nf_load;
    logic [9:0] nf_in;
    logic       cinit_run;
    logic       est_ack;
    logic       new_frame;
    logic       new_subframe;
    logic       first_run;
    logic       last_run;
    logic [4:0] cinit_ns;
    logic [2:0] cinit_l;
    logic [3:0] sf_num;
    logic [9:0] nf_num;
    logic       sf_done;
    logic       sf_skipped;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    // Model: absolute subframe index nf*10+sf, modulo 10240.
    int m_abs  = 10239;

    nrs_subframe_scheduler #(
        .NUM_RUNS  (4),
        .SKIP_MASK (10'b0000100001),
        .NSSS_SKIP (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sf_tick      (sf_tick),
        .nf_load      (nf_load),
        .nf_in        (nf_in),
        .cinit_run    (cinit_run),
        .est_ack      (est_ack),
        .new_frame    (new_frame),
        .new_subframe (new_subframe),
        .first_run    (first_run),
        .last_run     (last_run),
        .cinit_ns     (cinit_ns),
        .cinit_l      (cinit_l),
        .sf_num       (sf_num),
        .nf_num       (nf_num),
        .sf_done      (sf_done),
        .sf_skipped   (sf_skipped),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1);
    end

    function automatic bit m_skip(input int a);
        int sf = a % 10;
        int nf = a / 10;
        return (sf == 0) || (sf == 5) || ((sf == 9) && (nf % 2 == 0));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; sf_tick = 1'b0; nf_load = 1'b0; nf_in = '0;
        cinit_run = 1'b0; est_ack = 1'b0;
        step(); step();
        checks++;
        if (sf_num !== 4'd9 || nf_num !== 10'd1023) begin
            errors++;
            $display("FAIL reset_counters: got sf=%0d nf=%0d want sf=9 nf=1023", sf_num, nf_num);
        end
        checks++;
        if ({new_frame, new_subframe, first_run, last_run, sf_done, sf_skipped, overrun} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {new_frame, new_subframe, first_run, last_run, sf_done, sf_skipped, overrun});
        end
        rst = 1'b1;
        step();
        m_abs = 10239;
    endtask

    // Issue one subframe tick from IDLE and check the counters and the
    // pulse that follows it; leaves the DUT in START when not skipped.
    task automatic tick_subframe(output bit skipped);
        int sf;
        sf_tick = 1'b1;
        step();
        sf_tick = 1'b0;
        m_abs   = (m_abs + 1) % 10240;
        sf      = m_abs % 10;
        skipped = m_skip(m_abs);
        checks++;
        if (sf_num !== 4'(sf) || nf_num !== 10'(m_abs / 10)) begin
            errors++;
            $display("FAIL tick_counters: got sf=%0d nf=%0d want sf=%0d nf=%0d", sf_num, nf_num, sf, m_abs / 10);
        end
        checks++;
        if (sf_skipped !== skipped || new_frame !== (!skipped && sf == 0) || new_subframe !== (!skipped && sf != 0)) begin
            errors++;
            $display("FAIL tick_pulses: got skip=%b nfr=%b nsf=%b want skip=%b (sf=%0d nf=%0d)",
                     sf_skipped, new_frame, new_subframe, skipped, sf, m_abs / 10);
        end
        if (!skipped) begin
            checks++;
            if (cinit_ns !== 5'(2 * sf) || cinit_l !== 3'd5) begin
                errors++;
                $display("FAIL start_indices: got ns=%0d l=%0d want ns=%0d l=5", cinit_ns, cinit_l, 2 * sf);
            end
        end else begin
            step();
            checks++;
            if (sf_skipped !== 1'b0) begin
                errors++;
                $display("FAIL skip_pulse_width: got %b want 0", sf_skipped);
            end
        end
    endtask

    // From START: random request/ack interleaving until sf_done.
    task automatic run_handshake();
        int  sf   = m_abs % 10;
        int  reqs = 0;
        int  acks = 0;
        bit  done = 1'b0;
        step();
        checks++;
        if (new_frame !== 1'b0 || new_subframe !== 1'b0) begin
            errors++;
            $display("FAIL start_pulse_width: got nfr=%b nsf=%b want 0 0", new_frame, new_subframe);
        end
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            int pre_reqs = reqs;
            bit do_req;
            bit do_ack;
            if (reqs < 4) begin
                checks++;
                if (cinit_ns !== 5'(2 * sf + reqs / 2) || cinit_l !== 3'(5 + reqs % 2)) begin
                    errors++;
                    $display("FAIL run_indices: req %0d got ns=%0d l=%0d want ns=%0d l=%0d",
                             reqs, cinit_ns, cinit_l, 2 * sf + reqs / 2, 5 + reqs % 2);
                end
            end
            checks++;
            if (first_run !== (reqs == 1) || last_run !== (reqs == 4) || sf_done !== 1'b0) begin
                errors++;
                $display("FAIL run_flags: reqs=%0d got first=%b last=%b done=%b want first=%b last=%b done=0",
                         reqs, first_run, last_run, sf_done, reqs == 1, reqs == 4);
            end
            do_req    = (reqs < 4) && ($urandom_range(0, 2) == 0);
            do_ack    = (acks < reqs) && ($urandom_range(0, 2) == 0);
            // Spurious requests once all runs are issued must be ignored.
            cinit_run = do_req || ((reqs == 4) && ($urandom_range(0, 3) == 0));
            est_ack   = do_ack;
            step();
            cinit_run = 1'b0;
            est_ack   = 1'b0;
            if (do_req) reqs++;
            if (do_ack) acks++;
            if (pre_reqs == 4 && acks == 4) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: got reqs=%0d acks=%0d want 4 4", reqs, acks);
        end else begin
            checks++;
            if (sf_done !== 1'b1 || first_run !== 1'b0 || last_run !== 1'b0) begin
                errors++;
                $display("FAIL sf_done: got done=%b first=%b last=%b want 1 0 0", sf_done, first_run, last_run);
            end
            step();
            checks++;
            if (sf_done !== 1'b0) begin
                errors++;
                $display("FAIL sf_done_width: got %b want 0", sf_done);
            end
        end
    endtask

    task automatic process_subframe();
        bit sk;
        tick_subframe(sk);
        if (!sk) run_handshake();
    endtask

    // Load with a coincident tick, which must be dropped.
    task automatic load_frame(input int n);
        nf_load = 1'b1;
        nf_in   = 10'(n);
        sf_tick = 1'b1;
        step();
        nf_load = 1'b0;
        sf_tick = 1'b0;
        m_abs   = (n * 10 + 10239) % 10240;
        checks++;
        if (sf_num !== 4'd9 || nf_num !== 10'(n) || sf_skipped !== 1'b0 || new_frame !== 1'b0 || new_subframe !== 1'b0) begin
            errors++;
            $display("FAIL load_frame: got sf=%0d nf=%0d skip=%b nfr=%b nsf=%b want sf=9 nf=%0d 0 0 0",
                     sf_num, nf_num, sf_skipped, new_frame, new_subframe, n);
        end
    endtask

    // Pure stimulus: START -> RUN, four requests, three acks.
    task automatic drive_to_last_ack();
        step();
        cinit_run = 1'b1;
        repeat (4) step();
        cinit_run = 1'b0;
        est_ack   = 1'b1;
        repeat (3) step();
        est_ack   = 1'b0;
    endtask

    task automatic test_first_subframes();
        process_subframe();
        process_subframe();
    endtask

    task automatic test_frame_sweep();
        load_frame(6);
        repeat (10) process_subframe();
        load_frame(7);
        repeat (10) process_subframe();
        load_frame(1023);
        repeat (11) process_subframe();
        load_frame($urandom_range(0, 1022));
        repeat (10) process_subframe();
    endtask

    task automatic test_overrun();
        bit sk;
        load_frame(20);
        tick_subframe(sk);
        tick_subframe(sk);
        step();
        cinit_run = 1'b1;
        step();
        cinit_run = 1'b0;
        sf_tick   = 1'b1;
        step();
        sf_tick   = 1'b0;
        m_abs     = (m_abs + 1) % 10240;
        checks++;
        if (overrun !== 1'b1 || sf_num !== 4'(m_abs % 10) || first_run !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: got ovr=%b sf=%0d first=%b want 1 %0d 1", overrun, sf_num, first_run, m_abs % 10);
        end
        step();
        checks++;
        if (new_subframe !== 1'b0 || new_frame !== 1'b0 || sf_skipped !== 1'b0) begin
            errors++;
            $display("FAIL overrun_no_start: got nfr=%b nsf=%b skip=%b want 0 0 0", new_frame, new_subframe, sf_skipped);
        end
        cinit_run = 1'b1;
        repeat (3) step();
        cinit_run = 1'b0;
        checks++;
        if (last_run !== 1'b1) begin
            errors++;
            $display("FAIL overrun_last_run: got %b want 1", last_run);
        end
        est_ack = 1'b1;
        repeat (4) step();
        est_ack = 1'b0;
        checks++;
        if (sf_done !== 1'b1 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_done: got done=%b ovr=%b want 1 1", sf_done, overrun);
        end
        repeat (3) step();
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky: got %b want 1", overrun);
        end
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        m_abs = 10239;
    endtask

    task automatic test_back_to_back();
        bit sk;
        process_subframe();
        process_subframe();
        tick_subframe(sk);
        drive_to_last_ack();
        sf_tick = 1'b1;
        est_ack = 1'b1;
        step();
        sf_tick = 1'b0;
        est_ack = 1'b0;
        m_abs   = (m_abs + 1) % 10240;
        checks++;
        if (sf_done !== 1'b1 || new_subframe !== 1'b1 || new_frame !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_pulses: got done=%b nsf=%b nfr=%b ovr=%b want 1 1 0 0", sf_done, new_subframe, new_frame, overrun);
        end
        checks++;
        if (sf_num !== 4'd3 || cinit_ns !== 5'd6 || cinit_l !== 3'd5) begin
            errors++;
            $display("FAIL b2b_indices: got sf=%0d ns=%0d l=%0d want 3 6 5", sf_num, cinit_ns, cinit_l);
        end
        run_handshake();
        tick_subframe(sk);
        drive_to_last_ack();
        sf_tick = 1'b1;
        est_ack = 1'b1;
        step();
        sf_tick = 1'b0;
        est_ack = 1'b0;
        m_abs   = (m_abs + 1) % 10240;
        checks++;
        if (sf_done !== 1'b1 || sf_skipped !== 1'b1 || new_subframe !== 1'b0 || overrun !== 1'b0 || sf_num !== 4'd5) begin
            errors++;
            $display("FAIL b2b_skip: got done=%b skip=%b nsf=%b ovr=%b sf=%0d want 1 1 0 0 5",
                     sf_done, sf_skipped, new_subframe, overrun, sf_num);
        end
        step();
        checks++;
        if (sf_skipped !== 1'b0 || sf_done !== 1'b0 || first_run !== 1'b0 || last_run !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got skip=%b done=%b first=%b last=%b want 0 0 0 0", sf_skipped, sf_done, first_run, last_run);
        end
    endtask

    task automatic test_reset_midop();
        bit sk;
        tick_subframe(sk);
        step();
        cinit_run = 1'b1;
        repeat (4) step();
        cinit_run = 1'b0;
        est_ack   = 1'b1;
        step();
        est_ack   = 1'b0;
        checks++;
        if (last_run !== 1'b1) begin
            errors++;
            $display("FAIL midop_precondition: got last=%b want 1", last_run);
        end
        rst = 1'b0;
        #2;
        checks++;
        if (sf_num !== 4'd9 || nf_num !== 10'd1023 ||
            {new_frame, new_subframe, first_run, last_run, sf_done, sf_skipped, overrun} !== 7'b0) begin
            errors++;
            $display("FAIL midop_async_reset: got sf=%0d nf=%0d flags=%b want 9 1023 0000000", sf_num, nf_num,
                     {new_frame, new_subframe, first_run, last_run, sf_done, sf_skipped, overrun});
        end
        step();
        rst = 1'b1;
        step();
        m_abs = 10239;
        process_subframe();
        process_subframe();
    endtask

    initial begin
        test_reset();
        test_first_subframes();
        test_frame_sweep();
        test_overrun();
        test_back_to_back();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
